// File: rtl/hyperloglog_dma_cmd_gen.sv
// Splits an HLL job descriptor into page-safe DMA read commands and forwards
// the returned data beats to the HLL pipeline with last/keep on the final beat,
// counting the tuples handed over.
module hyperloglog_dma_cmd_gen #(
  parameter int DATA_BYTES      = 64,
  parameter int TUPLE_BYTES     = 4,
  parameter int MAX_BURST_BYTES = 1024
) (
  input  logic                    user_clk,
  input  logic                    user_aresetn,
  input  logic                    s_axis_param_valid,
  output logic                    s_axis_param_ready,
  input  logic [95:0]             s_axis_param_data,
  output logic                    m_axis_dma_cmd_valid,
  input  logic                    m_axis_dma_cmd_ready,
  output logic [63:0]             m_axis_dma_cmd_addr,
  output logic [31:0]             m_axis_dma_cmd_len,
  input  logic                    s_axis_data_valid,
  output logic                    s_axis_data_ready,
  input  logic [DATA_BYTES*8-1:0] s_axis_data_data,
  output logic                    m_axis_data_valid,
  input  logic                    m_axis_data_ready,
  output logic [DATA_BYTES*8-1:0] m_axis_data_data,
  output logic [DATA_BYTES-1:0]   m_axis_data_keep,
  output logic                    m_axis_data_last,
  output logic [31:0]             tuples_consumed,
  output logic                    busy,
  output logic                    done
);

  localparam int BEAT_SH = $clog2(DATA_BYTES);
  localparam int TUP_SH  = $clog2(TUPLE_BYTES);
  localparam int TPB     = DATA_BYTES / TUPLE_BYTES;

  typedef enum logic [1:0] {IDLE, CMD, DRAIN, DONE} state_t;

  state_t             state_q, state_d;
  logic [63:0]        addr_q, addr_d;
  logic [39:0]        bytes_left_q, bytes_left_d;
  logic [39:0]        total_beats_q, total_beats_d;
  logic [39:0]        beats_q, beats_d;
  logic [BEAT_SH-1:0] rem_q, rem_d;
  logic [31:0]        len_q, len_d;
  logic [31:0]        tuples_q, tuples_d;

  logic        active;
  logic        beat_hs;
  logic        is_last;
  logic [39:0] job_bytes;

  // Largest command that fits the remaining bytes, the burst limit and the page.
  function automatic logic [39:0] burst_len(input logic [63:0] a, input logic [39:0] b);
    logic [39:0] lim;
    logic [12:0] page;
    page = 13'd4096 - {1'b0, a[11:0]};
    lim  = 40'(MAX_BURST_BYTES);
    if ({27'b0, page} < lim) lim = {27'b0, page};
    if (b < lim) lim = b;
    return lim;
  endfunction

  // Byte enables for a beat carrying r valid bytes (r == 0 means a full beat).
  function automatic logic [DATA_BYTES-1:0] keep_mask(input logic [BEAT_SH-1:0] r);
    logic [DATA_BYTES-1:0] m;
    m = '1;
    if (r != '0) m = m >> (DATA_BYTES - int'(r));
    return m;
  endfunction

  // Zero-latency data pass-through, only open while a job is moving data.
  always_comb begin
    active             = (state_q == CMD) || (state_q == DRAIN);
    m_axis_data_valid  = active && s_axis_data_valid;
    s_axis_data_ready  = active && m_axis_data_ready;
    m_axis_data_data   = s_axis_data_data;
    beat_hs            = s_axis_data_valid && s_axis_data_ready;
    is_last            = active && (beats_q == total_beats_q - 40'd1);
    m_axis_data_last   = is_last;
    m_axis_data_keep   = is_last ? keep_mask(rem_q) : '1;
    job_bytes          = 40'(s_axis_param_data[95:64]) << TUP_SH;
  end

  // Next-state logic: descriptor capture, command splitting, beat accounting.
  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    bytes_left_d  = bytes_left_q;
    total_beats_d = total_beats_q;
    beats_d       = beats_q;
    rem_d         = rem_q;
    len_d         = len_q;
    tuples_d      = tuples_q;

    if (beat_hs) begin
      beats_d  = beats_q + 40'd1;
      tuples_d = tuples_q + ((is_last && rem_q != '0) ? 32'(rem_q >> TUP_SH) : 32'(TPB));
    end

    case (state_q)
      IDLE: begin
        if (s_axis_param_valid) begin
          addr_d        = s_axis_param_data[63:0] & ~64'(DATA_BYTES - 1);
          bytes_left_d  = job_bytes;
          total_beats_d = (job_bytes + 40'(DATA_BYTES - 1)) >> BEAT_SH;
          rem_d         = job_bytes[BEAT_SH-1:0];
          len_d         = 32'(burst_len(addr_d, job_bytes));
          beats_d       = '0;
          tuples_d      = '0;
          state_d       = (s_axis_param_data[95:64] == 32'd0) ? DONE : CMD;
        end
      end
      CMD: begin
        if (m_axis_dma_cmd_ready) begin
          addr_d       = addr_q + 64'(len_q);
          bytes_left_d = bytes_left_q - 40'(len_q);
          len_d        = 32'(burst_len(addr_d, bytes_left_d));
          if (bytes_left_d == '0)
            state_d = (beats_d == total_beats_q) ? DONE : DRAIN;
        end
      end
      DRAIN: begin
        if (beats_d == total_beats_q) state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and counter registers with synchronous active-low reset.
  always_ff @(posedge user_clk) begin
    if (!user_aresetn) begin
      state_q       <= IDLE;
      addr_q        <= '0;
      bytes_left_q  <= '0;
      total_beats_q <= '0;
      beats_q       <= '0;
      rem_q         <= '0;
      len_q         <= '0;
      tuples_q      <= '0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      bytes_left_q  <= bytes_left_d;
      total_beats_q <= total_beats_d;
      beats_q       <= beats_d;
      rem_q         <= rem_d;
      len_q         <= len_d;
      tuples_q      <= tuples_d;
    end
  end

  // Registered command and status outputs.
  always_comb begin
    s_axis_param_ready   = user_aresetn && (state_q == IDLE);
    m_axis_dma_cmd_valid = (state_q == CMD);
    m_axis_dma_cmd_addr  = addr_q;
    m_axis_dma_cmd_len   = len_q;
    tuples_consumed      = tuples_q;
    busy                 = (state_q != IDLE);
    done                 = (state_q == DONE);
  end

endmodule
